fifo_sync: RTL and testbench

Parametrised synchronous FIFO with internal storage, the next generation of the team's single-strobe push/pull FIFO. It replaces the shared `op` strobe with independent push and pop strobes that can act in the same cycle, and uses all DEPTH entries (no sacrificed slot). It also adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It sits between producer and consumer blocks in the same clock domain: UART byte buffering, command queues, logger sample queues.

---
 rtl/fifo_sync.sv | 83 ++++++++
 tb/tb_fifo_sync.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync.sv
// Synchronous FIFO with independent push/pop strobes, all DEPTH entries usable.
// Latency: a push is visible on data_read right after its edge; status flags update at the accepting edge.
// Backpressure: push is refused while full (sets sticky overflow), pop is refused while empty (sets sticky underflow).
//
// Ports:
//   clk, reset_n (async active-low), clear (sync flush, wins over push/pop)
//   push/data_write in, pop in, data_read out (show-ahead head entry)
//   full, empty, almost_full, almost_empty, count, overflow, underflow
module fifo_sync #(
  parameter  int DW       = 8,
  parameter  int DEPTH    = 10,
  parameter  int AF_LEVEL = 8,
  parameter  int AE_LEVEL = 2,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] data_write,
  input  logic          pop,
  output logic [DW-1:0] data_read,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Pointers run 0..DEPTH-1 so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Both accept decisions look at pre-edge occupancy, so a pop frees no
  // room for a push in the same cycle when full (and vice versa when empty).
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
      if (push && full)  overflow  <= 1'b1;
      if (pop && empty)  underflow <= 1'b1;
    end
  end

  // Storage is not reset; a push coinciding with clear is dropped.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= data_write;
  end

  assign data_read    = mem[rd_ptr];
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_fifo_sync.sv
module tb_fifo_sync;
  localparam int DEPTH = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0, push = 1'b0, pop = 1'b0;
  logic [7:0] data_write = 8'h00;
  logic [7:0] data_read;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  logic        push2 = 1'b0, pop2 = 1'b0, clear2 = 1'b0;
  logic [11:0] dw2 = 12'h000;
  logic [11:0] dr2;
  logic        full2, empty2, af2, ae2, ovf2, unf2;
  logic [4:0]  count2;

  always #5 clk = ~clk;

  fifo_sync dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .push(push),
    .data_write(data_write), .pop(pop), .data_read(data_read),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_sync #(.DW(12), .DEPTH(16), .AF_LEVEL(16), .AE_LEVEL(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .clear(clear2), .push(push2),
    .data_write(dw2), .pop(pop2), .data_read(dr2),
    .full(full2), .empty(empty2), .almost_full(af2),
    .almost_empty(ae2), .count(count2),
    .overflow(ovf2), .underflow(unf2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain queue plus two sticky bits.
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0, m_unf = 1'b0;

  typedef struct {
    bit       clr, psh, pp;
    logic [7:0] d;
    int       cnt;
    bit       emp, ful, af, ae, ovf, unf;
    bit       chk_d;
    logic [7:0] exp_d;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string tag, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", tag, name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit p, input bit q, input logic [7:0] d);
    bit f, e;
    if (c) begin
      model_reset();
    end else begin
      f = (mq.size() == DEPTH);
      e = (mq.size() == 0);
      if (p && f) m_ovf = 1'b1;
      if (q && e) m_unf = 1'b1;
      if (q && !e) void'(mq.pop_front());
      if (p && !f) mq.push_back(d);
    end
  endtask

  task automatic apply(input bit c, input bit p, input bit q, input logic [7:0] d);
    clear = c; push = p; pop = q; data_write = d;
    @(posedge clk);
    #1;
    model_step(c, p, q, d);
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk(tag, "count", 32'(count), 32'(n));
    chk(tag, "empty", 32'(empty), 32'(n == 0));
    chk(tag, "full", 32'(full), 32'(n == DEPTH));
    chk(tag, "almost_full", 32'(almost_full), 32'(n >= 8));
    chk(tag, "almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk(tag, "overflow", 32'(overflow), 32'(m_ovf));
    chk(tag, "underflow", 32'(underflow), 32'(m_unf));
    if (n > 0) chk(tag, "data_read", 32'(data_read), 32'(mq[0]));
  endtask

  function automatic vec_t mk(bit c, bit p, bit q, logic [7:0] d, int cnt,
                              bit ovf, bit unf, bit chk_d, logic [7:0] exp_d);
    vec_t v;
    v.clr = c; v.psh = p; v.pp = q; v.d = d; v.cnt = cnt;
    v.emp = (cnt == 0); v.ful = (cnt == 10);
    v.af = (cnt >= 8); v.ae = (cnt <= 2);
    v.ovf = ovf; v.unf = unf; v.chk_d = chk_d; v.exp_d = exp_d;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Directed vector table.
    for (int i = 1; i <= 10; i++) vt.push_back(mk(0, 1, 0, 8'(i), i, 0, 0, 1, 8'h01));
    vt.push_back(mk(0, 1, 0, 8'hFF, 10, 1, 0, 1, 8'h01));
    for (int i = 1; i <= 10; i++) vt.push_back(mk(0, 0, 1, 8'h00, 10 - i, 1, 0, i < 10, 8'(i + 1)));
    vt.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
    vt.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 8'h00));
    vt.push_back(mk(0, 1, 1, 8'h55, 1, 0, 1, 1, 8'h55));
    vt.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));

    // Reset state before any clock edge.
    #2;
    check_model("reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Mid-stream asynchronous reset.
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 8'hA0 + 8'(i));
    check_model("prefill");
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply(0, 0, 0, 8'h00);
    check_model("post_reset");

    // Table-driven directed vectors.
    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].clr, vt[i].psh, vt[i].pp, vt[i].d);
      chk("vec", "count", 32'(count), 32'(vt[i].cnt));
      chk("vec", "empty", 32'(empty), 32'(vt[i].emp));
      chk("vec", "full", 32'(full), 32'(vt[i].ful));
      chk("vec", "almost_full", 32'(almost_full), 32'(vt[i].af));
      chk("vec", "almost_empty", 32'(almost_empty), 32'(vt[i].ae));
      chk("vec", "overflow", 32'(overflow), 32'(vt[i].ovf));
      chk("vec", "underflow", 32'(underflow), 32'(vt[i].unf));
      if (vt[i].chk_d) chk("vec", "data_read", 32'(data_read), 32'(vt[i].exp_d));
    end

    // Steady simultaneous traffic at count 5; pointers wrap repeatedly.
    for (int i = 0; i < 5; i++) apply(0, 1, 0, 8'h20 + 8'(i));
    for (int k = 0; k < 20; k++) begin
      apply(0, 1, 1, 8'h30 + 8'(k));
      chk("traffic", "count", 32'(count), 32'd5);
      chk("traffic", "data_read", 32'(data_read), 32'(k < 4 ? 8'h21 + 8'(k) : 8'h30 + 8'(k - 4)));
      check_model("traffic");
    end
    chk("traffic", "overflow", 32'(overflow), 32'd0);
    chk("traffic", "underflow", 32'(underflow), 32'd0);

    // Clear beats simultaneous push and pop.
    apply(0, 0, 1, 8'h00);
    chk("clrprio", "count_before", 32'(count), 32'd4);
    apply(1, 1, 1, 8'hAA);
    chk("clrprio", "count", 32'(count), 32'd0);
    chk("clrprio", "empty", 32'(empty), 32'd1);
    chk("clrprio", "almost_empty", 32'(almost_empty), 32'd1);
    apply(0, 1, 0, 8'h11);
    chk("clrprio", "count_after", 32'(count), 32'd1);
    chk("clrprio", "data_after", 32'(data_read), 32'h11);
    apply(1, 0, 0, 8'h00);

    // Randomised traffic against the queue model, biased to reach full then empty.
    for (int i = 0; i < 400; i++) begin
      bit c, p, q;
      c = ($urandom_range(0, 49) == 0);
      p = ($urandom_range(0, 99) < (i < 200 ? 75 : 25));
      q = ($urandom_range(0, 99) < (i < 200 ? 25 : 75));
      apply(c, p, q, 8'($urandom));
      check_model("random");
    end

    // Second asynchronous reset in the middle of traffic.
    apply(0, 1, 0, 8'h77);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_model("async_reset2");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply(0, 0, 0, 8'h00);
    check_model("post_reset2");

    // Non-default parameter instance: full fill then drain.
    begin
      int n2;
      n2 = 0;
      for (int i = 0; i < 17; i++) begin
        push2 = 1'b1; pop2 = 1'b0; dw2 = 12'h0A0 + 12'(i);
        @(posedge clk);
        #1;
        if (n2 < 16) n2++;
        chk("p16_fill", "count", 32'(count2), 32'(n2));
        chk("p16_fill", "full", 32'(full2), 32'(n2 == 16));
        chk("p16_fill", "almost_full", 32'(af2), 32'(n2 == 16));
        chk("p16_fill", "almost_empty", 32'(ae2), 32'(n2 == 0));
        chk("p16_fill", "overflow", 32'(ovf2), 32'(i == 16));
      end
      for (int i = 0; i < 17; i++) begin
        if (i < 16) chk("p16_drain", "data_read", 32'(dr2), 32'(12'h0A0 + 12'(i)));
        push2 = 1'b0; pop2 = 1'b1;
        @(posedge clk);
        #1;
        if (n2 > 0) n2--;
        chk("p16_drain", "count", 32'(count2), 32'(n2));
        chk("p16_drain", "empty", 32'(empty2), 32'(n2 == 0));
        chk("p16_drain", "almost_full", 32'(af2), 32'd0);
        chk("p16_drain", "almost_empty", 32'(ae2), 32'(n2 == 0));
        chk("p16_drain", "underflow", 32'(unf2), 32'(i == 16));
      end
      pop2 = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
